multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multi-cycle sequencer for the MIPS datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB states, and drives the datapath's register-file, ALU, mux and extender controls from the current state and the IR opcode/funct. It handshakes with instruction and data memory that can insert wait states. It replaces the purely combinational opcode decode as the owner of all datapath write enables.

## Interface
- No parameters; encodings come from the shared constants.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  6  IR[31:26]; held stable by the datapath between `ir_write` pulses.
- `funct`  in  6  IR[5:0].
- `alu_zero`  in  1  ALU zero flag, valid in EXEC.
- `im_ready`  in  1  instruction memory has `instr` for the current PC.
- `dm_ready`  in  1  data memory access is complete.
- `im_req`  out  1  instruction fetch request.
- `dm_req`  out  1  data memory request.
- `dm_we`  out  1  data memory write (SW).
- `ir_write`, `pc_write`  out  1 each  IR load / PC load.
- `pc_src`  out  2  `SEL_PC_PC4`, `SEL_PC_BRANCH` or `SEL_PC_JUMP`.
- `reg_write`  out  1  register-file write enable.
- `reg_dst`  out  2  `SEL_REGDST_RT` or `SEL_REGDST_RD`.
- `wb_sel`  out  2  `SEL_WB_ALUOUT` or `SEL_WB_DM`.
- `alu_src`  out  1  `SEL_ALUSRC_REG` or `SEL_ALUSRC_IMM`.
- `imm_ext`  out  1  `EXT_MODE_SIGNED` or `EXT_MODE_UNSIGNED`.
- `alu_op`  out  5  `ALUOp_*` code.
- `illegal`  out  1  one-cycle pulse on an unsupported opcode or funct.
- `retired`  out  32  count of completed instructions, wraps at 2^32.
- `state`  out  3  current state, for debug.

## Operation
- **States:** FETCH, DECODE, EXEC, MEM, WB.
- **FETCH:** `im_req`=1 every cycle in this state.
  - `im_ready`=0: stay in FETCH.
  - `im_ready`=1: in that same cycle assert `ir_write`=1, `pc_write`=1, `pc_src`=PC4, then go to DECODE.
- **DECODE (1 cycle):** legality check.
  - Illegal opcode or R-type funct: `illegal`=1, go to FETCH, no writes.
  - Otherwise go to EXEC.
- **Supported opcodes:** R-type, ADDI, ADDIU, ANDI, ORI, XORI, LUI, LW, SW, BEQ, J.
- **Supported R-type funct:** ADD, ADDU, SUB, AND, OR, XOR, SLT.
- **EXEC (1 cycle):** `alu_op`, `alu_src` and `imm_ext` come from the decode map.
  - LW and SW go to MEM.
  - BEQ: `alu_op`=SUB, `pc_write`=`alu_zero`, `pc_src`=BRANCH, go to FETCH.
  - J: `pc_write`=1, `pc_src`=JUMP, go to FETCH.
  - All others go to WB.
- **MEM:** `dm_req`=1 every cycle in this state; `dm_we`=1 for SW.
  - `alu_op`=ADD and `alu_src`=IMM with `imm_ext`=SIGNED stay driven throughout.
  - `dm_ready`=0: stay in MEM.
  - `dm_ready`=1: SW goes to FETCH; LW goes to WB.
- **WB (1 cycle):** `reg_write`=1 and `alu_op` stays driven; go to FETCH.
  - `reg_dst`=RD for R-type, RT otherwise.
  - `wb_sel`=DM for LW, ALUOUT otherwise.
- **Decode map:**
  - ADDI, LW, SW: ADD with SIGNED extension.
  - ADDIU: ADDU, UNSIGNED.
  - ANDI, ORI, XORI: AND, OR, XOR, UNSIGNED.
  - LUI: LUI, UNSIGNED.
  - R-type: funct maps to the matching `ALUOp_*`; `alu_src`=REG.
- **Defaults:** every output not listed for a state is 0.
- **`retired`:** increments by 1 on each instruction completion:
  - leaving WB;
  - leaving MEM for SW;
  - leaving EXEC for BEQ or J.
  - Illegal instructions do not count.

## Timing
- **Outputs:** combinational from the registered state, opcode, funct and handshake inputs. `retired` is registered.
- **Cycles per instruction (zero-wait memory):**
  - ALU ops: 4.
  - SW: 4.
  - LW: 5.
  - BEQ and J: 3.
  - Illegal: 2.
- **Wait states:** each cycle with `im_ready`=0 in FETCH or `dm_ready`=0 in MEM adds 1 cycle.
- **Handshake inputs outside their states:** `im_ready` outside FETCH and `dm_ready` outside MEM are ignored.
- **Reset:**
  - While `rst`=1, all outputs are forced to 0, including `im_req` and `dm_req`.
  - The next state is FETCH and `retired` becomes 0.
  - Reset mid-MEM or mid-FETCH abandons the access; no write enables fire in the reset cycle.
  - The first `im_req` appears in the first cycle with `rst`=0.

## Structure
- **Shared header:**
  - state encoding;
  - `INSTR_OP_*` and `INSTR_FUNCT_*` constants, with BEQ, J and the R-type functs added;
  - `ALUOp_*` codes;
  - `SEL_*` mux codes;
  - `EXT_MODE_*` codes.
- **Sub-module `mc_decode`:** combinational opcode/funct to {legal, `alu_op`, `alu_src`, `imm_ext`, `reg_dst`, `wb_sel`, class}. `multicycle_ctrl` holds the FSM, the handshake logic and the `retired` counter.

## Test plan
- **ADDI, zero-wait:** `rst` 2 cycles, then opcode=ADDI with `im_ready`=1.
  - State sequence FETCH, DECODE, EXEC, WB, FETCH.
  - WB has `reg_write`=1, `reg_dst`=RT, `wb_sel`=ALUOUT, `alu_op`=ADD.
  - `retired`=1 after 4 cycles.
- **LW with waits:** `im_ready` low 2 cycles, `dm_ready` low 3 cycles.
  - 10 cycles total.
  - `dm_req` held for 4 cycles with `dm_we`=0.
  - WB has `wb_sel`=DM.
- **BEQ:** run once with `alu_zero`=1 and once with `alu_zero`=0.
  - EXEC has `pc_write`=1 and `pc_src`=BRANCH in the first case, `pc_write`=0 in the second.
  - Each takes 3 cycles and each increments `retired`.
- **Illegal:** opcode=6'b111111, then R-type with funct=6'b000111.
  - `illegal` pulses in DECODE for both.
  - No `reg_write`, `dm_req` or `pc_write` after FETCH.
  - `retired` unchanged.
- **Reset mid-MEM:** SW with `dm_ready`=0, then assert `rst` for 1 cycle.
  - All outputs are 0 in the reset cycle.
  - The next cycle is FETCH with `im_req`=1, `retired`=0, and no `dm_we`.
- **Wrap:** force `retired` to 32'hFFFFFFFF, then complete J.
  - `retired` becomes 0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: states, instruction
// fields, ALU operation codes, datapath mux selects and extender modes.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4
  } state_e;

  // Instruction opcodes (IR[31:26])
  localparam logic [5:0] INSTR_OP_RTYPE = 6'h00;
  localparam logic [5:0] INSTR_OP_J     = 6'h02;
  localparam logic [5:0] INSTR_OP_BEQ   = 6'h04;
  localparam logic [5:0] INSTR_OP_ADDI  = 6'h08;
  localparam logic [5:0] INSTR_OP_ADDIU = 6'h09;
  localparam logic [5:0] INSTR_OP_ANDI  = 6'h0c;
  localparam logic [5:0] INSTR_OP_ORI   = 6'h0d;
  localparam logic [5:0] INSTR_OP_XORI  = 6'h0e;
  localparam logic [5:0] INSTR_OP_LUI   = 6'h0f;
  localparam logic [5:0] INSTR_OP_LW    = 6'h23;
  localparam logic [5:0] INSTR_OP_SW    = 6'h2b;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] INSTR_FUNCT_ADD  = 6'h20;
  localparam logic [5:0] INSTR_FUNCT_ADDU = 6'h21;
  localparam logic [5:0] INSTR_FUNCT_SUB  = 6'h22;
  localparam logic [5:0] INSTR_FUNCT_AND  = 6'h24;
  localparam logic [5:0] INSTR_FUNCT_OR   = 6'h25;
  localparam logic [5:0] INSTR_FUNCT_XOR  = 6'h26;
  localparam logic [5:0] INSTR_FUNCT_SLT  = 6'h2a;

  // ALU operation codes; zero means "no operation requested"
  localparam logic [4:0] ALUOp_NONE = 5'd0;
  localparam logic [4:0] ALUOp_ADD  = 5'd1;
  localparam logic [4:0] ALUOp_ADDU = 5'd2;
  localparam logic [4:0] ALUOp_SUB  = 5'd3;
  localparam logic [4:0] ALUOp_AND  = 5'd4;
  localparam logic [4:0] ALUOp_OR   = 5'd5;
  localparam logic [4:0] ALUOp_XOR  = 5'd6;
  localparam logic [4:0] ALUOp_SLT  = 5'd7;
  localparam logic [4:0] ALUOp_LUI  = 5'd8;

  // Datapath mux selects
  localparam logic [1:0] SEL_PC_PC4     = 2'd0;
  localparam logic [1:0] SEL_PC_BRANCH  = 2'd1;
  localparam logic [1:0] SEL_PC_JUMP    = 2'd2;
  localparam logic [1:0] SEL_REGDST_RT  = 2'd0;
  localparam logic [1:0] SEL_REGDST_RD  = 2'd1;
  localparam logic [1:0] SEL_WB_ALUOUT  = 2'd0;
  localparam logic [1:0] SEL_WB_DM      = 2'd1;
  localparam logic       SEL_ALUSRC_REG = 1'b0;
  localparam logic       SEL_ALUSRC_IMM = 1'b1;

  // Immediate extender modes
  localparam logic EXT_MODE_UNSIGNED = 1'b0;
  localparam logic EXT_MODE_SIGNED   = 1'b1;

  // Instruction class, steers the FSM path after EXEC
  typedef enum logic [2:0] {
    ClsAlu    = 3'd0,
    ClsLoad   = 3'd1,
    ClsStore  = 3'd2,
    ClsBranch = 3'd3,
    ClsJump   = 3'd4
  } instr_class_e;

  // R-type funct to ALU op; ALUOp_NONE flags an unsupported funct
  function automatic logic [4:0] funct_to_aluop(input logic [5:0] funct);
    logic [4:0] op;
    op = ALUOp_NONE;
    case (funct)
      INSTR_FUNCT_ADD:  op = ALUOp_ADD;
      INSTR_FUNCT_ADDU: op = ALUOp_ADDU;
      INSTR_FUNCT_SUB:  op = ALUOp_SUB;
      INSTR_FUNCT_AND:  op = ALUOp_AND;
      INSTR_FUNCT_OR:   op = ALUOp_OR;
      INSTR_FUNCT_XOR:  op = ALUOp_XOR;
      INSTR_FUNCT_SLT:  op = ALUOp_SLT;
      default:          op = ALUOp_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle. master = sequencer, slave = datapath side.
interface multicycle_ctrl_if;
  import multicycle_ctrl_pkg::*;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        alu_zero;
  logic        im_ready;
  logic        dm_ready;

  logic        im_req;
  logic        dm_req;
  logic        dm_we;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        reg_write;
  logic [1:0]  reg_dst;
  logic [1:0]  wb_sel;
  logic        alu_src;
  logic        imm_ext;
  logic [4:0]  alu_op;
  logic        illegal;
  logic [31:0] retired;
  logic [2:0]  state;

  modport master (
    input  opcode, funct, alu_zero, im_ready, dm_ready,
    output im_req, dm_req, dm_we, ir_write, pc_write, pc_src, reg_write, reg_dst,
           wb_sel, alu_src, imm_ext, alu_op, illegal, retired, state
  );

  modport slave (
    output opcode, funct, alu_zero, im_ready, dm_ready,
    input  im_req, dm_req, dm_we, ir_write, pc_write, pc_src, reg_write, reg_dst,
           wb_sel, alu_src, imm_ext, alu_op, illegal, retired, state
  );

endinterface

// File: rtl/multicycle_ctrl_decode.sv
// mc_decode: purely combinational opcode/funct decode for the sequencer.
module mc_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output logic         legal,
  output logic [4:0]   alu_op,
  output logic         alu_src,
  output logic         imm_ext,
  output logic [1:0]   reg_dst,
  output logic [1:0]   wb_sel,
  output instr_class_e cls
);

  // Opcode/funct to control bundle; anything unmatched is illegal
  always_comb begin
    legal   = 1'b1;
    alu_op  = ALUOp_NONE;
    alu_src = SEL_ALUSRC_REG;
    imm_ext = EXT_MODE_UNSIGNED;
    reg_dst = SEL_REGDST_RT;
    wb_sel  = SEL_WB_ALUOUT;
    cls     = ClsAlu;
    case (opcode)
      INSTR_OP_RTYPE: begin
        alu_op  = funct_to_aluop(funct);
        legal   = (alu_op != ALUOp_NONE);
        reg_dst = SEL_REGDST_RD;
      end
      INSTR_OP_ADDI: begin
        alu_op  = ALUOp_ADD;
        alu_src = SEL_ALUSRC_IMM;
        imm_ext = EXT_MODE_SIGNED;
      end
      INSTR_OP_ADDIU: begin
        alu_op  = ALUOp_ADDU;
        alu_src = SEL_ALUSRC_IMM;
      end
      INSTR_OP_ANDI: begin
        alu_op  = ALUOp_AND;
        alu_src = SEL_ALUSRC_IMM;
      end
      INSTR_OP_ORI: begin
        alu_op  = ALUOp_OR;
        alu_src = SEL_ALUSRC_IMM;
      end
      INSTR_OP_XORI: begin
        alu_op  = ALUOp_XOR;
        alu_src = SEL_ALUSRC_IMM;
      end
      INSTR_OP_LUI: begin
        alu_op  = ALUOp_LUI;
        alu_src = SEL_ALUSRC_IMM;
      end
      INSTR_OP_LW: begin
        alu_op  = ALUOp_ADD;
        alu_src = SEL_ALUSRC_IMM;
        imm_ext = EXT_MODE_SIGNED;
        wb_sel  = SEL_WB_DM;
        cls     = ClsLoad;
      end
      INSTR_OP_SW: begin
        alu_op  = ALUOp_ADD;
        alu_src = SEL_ALUSRC_IMM;
        imm_ext = EXT_MODE_SIGNED;
        cls     = ClsStore;
      end
      INSTR_OP_BEQ: begin
        alu_op = ALUOp_SUB;
        cls    = ClsBranch;
      end
      INSTR_OP_J: begin
        cls = ClsJump;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer owning all datapath write
// enables, with instruction/data memory wait-state handshakes and a retire counter.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input logic              clk,
  input logic              rst,
  multicycle_ctrl_if.master bus
);

  state_e       state_q, state_d;
  logic [31:0]  retired_q, retired_d;
  logic         retire;

  logic         dec_legal;
  logic [4:0]   dec_alu_op;
  logic         dec_alu_src;
  logic         dec_imm_ext;
  logic [1:0]   dec_reg_dst;
  logic [1:0]   dec_wb_sel;
  instr_class_e dec_cls;

  mc_decode u_decode (
    .opcode  (bus.opcode),
    .funct   (bus.funct),
    .legal   (dec_legal),
    .alu_op  (dec_alu_op),
    .alu_src (dec_alu_src),
    .imm_ext (dec_imm_ext),
    .reg_dst (dec_reg_dst),
    .wb_sel  (dec_wb_sel),
    .cls     (dec_cls)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired_d = retire ? retired_q + 32'd1 : retired_q;

  // Next-state and control outputs; reset forces everything low
  always_comb begin
    state_d       = state_q;
    retire        = 1'b0;
    bus.im_req    = 1'b0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.ir_write  = 1'b0;
    bus.pc_write  = 1'b0;
    bus.pc_src    = SEL_PC_PC4;
    bus.reg_write = 1'b0;
    bus.reg_dst   = SEL_REGDST_RT;
    bus.wb_sel    = SEL_WB_ALUOUT;
    bus.alu_src   = SEL_ALUSRC_REG;
    bus.imm_ext   = EXT_MODE_UNSIGNED;
    bus.alu_op    = ALUOp_NONE;
    bus.illegal   = 1'b0;

    case (state_q)
      StFetch: begin
        bus.im_req = 1'b1;
        if (bus.im_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          bus.pc_src   = SEL_PC_PC4;
          state_d      = StDecode;
        end
      end
      StDecode: begin
        if (!dec_legal) begin
          bus.illegal = 1'b1;
          state_d     = StFetch;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        bus.alu_op  = dec_alu_op;
        bus.alu_src = dec_alu_src;
        bus.imm_ext = dec_imm_ext;
        case (dec_cls)
          ClsLoad, ClsStore: state_d = StMem;
          ClsBranch: begin
            bus.pc_write = bus.alu_zero;
            bus.pc_src   = SEL_PC_BRANCH;
            retire       = 1'b1;
            state_d      = StFetch;
          end
          ClsJump: begin
            bus.pc_write = 1'b1;
            bus.pc_src   = SEL_PC_JUMP;
            retire       = 1'b1;
            state_d      = StFetch;
          end
          default: state_d = StWb;
        endcase
      end
      StMem: begin
        // Address stays computed as base + sign-extended offset for the whole access
        bus.dm_req  = 1'b1;
        bus.dm_we   = (dec_cls == ClsStore);
        bus.alu_op  = ALUOp_ADD;
        bus.alu_src = SEL_ALUSRC_IMM;
        bus.imm_ext = EXT_MODE_SIGNED;
        if (bus.dm_ready) begin
          if (dec_cls == ClsStore) begin
            retire  = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end
      end
      StWb: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = dec_reg_dst;
        bus.wb_sel    = dec_wb_sel;
        bus.alu_op    = dec_alu_op;
        retire        = 1'b1;
        state_d       = StFetch;
      end
      default: state_d = StFetch;
    endcase

    if (rst) begin
      state_d       = StFetch;
      retire        = 1'b0;
      bus.im_req    = 1'b0;
      bus.dm_req    = 1'b0;
      bus.dm_we     = 1'b0;
      bus.ir_write  = 1'b0;
      bus.pc_write  = 1'b0;
      bus.pc_src    = SEL_PC_PC4;
      bus.reg_write = 1'b0;
      bus.reg_dst   = SEL_REGDST_RT;
      bus.wb_sel    = SEL_WB_ALUOUT;
      bus.alu_src   = SEL_ALUSRC_REG;
      bus.imm_ext   = EXT_MODE_UNSIGNED;
      bus.alu_op    = ALUOp_NONE;
      bus.illegal   = 1'b0;
    end
  end

  assign bus.state   = rst ? 3'd0 : state_q;
  assign bus.retired = rst ? 32'd0 : retired_q;

endmodule
